// File: rtl/iso7816_pkg.sv
// Shared types and defaults for the ISO7816 character cores.
package iso7816_pkg;

  // Receive frame sequencer states
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    ERRSIG
  } rxState_t;

  // Line levels for the start and stop bits (idle level is ~START_BIT)
  localparam logic START_BIT_DEFAULT = 1'b0;
  localparam logic STOP_BIT1_DEFAULT = 1'b1;

  // Smallest usable ETU length in comClk ticks
  localparam int unsigned MIN_CLOCKS_PER_BIT = 4;

endpackage

// File: rtl/rx_bit_timer.sv
// Receive bit timer: clk divider producing comClk and an ETU counter
// that yields the mid-bit sample strobe and the bit-boundary strobe.
module rx_bit_timer #(
  parameter int unsigned DIVIDER_WIDTH       = 1,
  parameter int unsigned CLOCK_PER_BIT_WIDTH = 13
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DIVIDER_WIDTH-1:0]       clkPerCycle,
  input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
  input  logic                           clear,
  output logic                           comClk,
  output logic                           sampleTick,
  output logic                           bitEnd
);

  logic [DIVIDER_WIDTH-1:0]       divCount;
  logic [CLOCK_PER_BIT_WIDTH-1:0] etuCount;
  logic [CLOCK_PER_BIT_WIDTH-1:0] lastCount;
  logic [CLOCK_PER_BIT_WIDTH-1:0] halfCount;

  assign lastCount = clocksPerBit - 1'b1;
  assign halfCount = clocksPerBit >> 1;

  // Divider: one-clk comClk pulse every clkPerCycle+1 clocks (constant 1 when 0)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divCount <= '0;
      comClk   <= 1'b0;
    end else if (divCount >= clkPerCycle) begin
      divCount <= '0;
      comClk   <= 1'b1;
    end else begin
      divCount <= divCount + 1'b1;
      comClk   <= 1'b0;
    end
  end

  // ETU counter: held at zero while cleared, wraps at clocksPerBit-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      etuCount <= '0;
    end else if (clear) begin
      etuCount <= '0;
    end else if (comClk) begin
      if (etuCount == lastCount) begin
        etuCount <= '0;
      end else begin
        etuCount <= etuCount + 1'b1;
      end
    end
  end

  // Strobes are qualified by the comClk tick that will advance the counter
  always_comb begin
    sampleTick = comClk & ~clear & (etuCount == halfCount);
    bitEnd     = comClk & ~clear & (etuCount == lastCount);
  end

endmodule

// File: rtl/iso_rx_core.sv
// ISO7816-3 / UART-style character receiver with parity check,
// error signalling and a single-entry holding buffer.
module iso_rx_core
  import iso7816_pkg::*;
#(
  parameter int unsigned DIVIDER_WIDTH       = 1,
  parameter int unsigned CLOCK_PER_BIT_WIDTH = 13,
  parameter logic        START_BIT           = START_BIT_DEFAULT,
  parameter logic        STOP_BIT1           = STOP_BIT1_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           serialIn,
  input  logic [DIVIDER_WIDTH-1:0]       clkPerCycle,
  input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
  input  logic                           oddParity,
  input  logic                           msbFirst,
  input  logic                           errSigEnable,
  input  logic                           ackFlags,
  output logic                           comClk,
  output logic [7:0]                     dataOut,
  output logic                           bufferFull,
  output logic                           parityError,
  output logic                           frameError,
  output logic                           overrun,
  output logic                           run,
  output logic                           errSigOe
);

  rxState_t   state;
  logic       rxMeta;
  logic       rxS;
  logic       rxPrev;
  logic [2:0] bitCounter;
  logic [2:0] bitIndex;
  logic [7:0] shiftReg;
  logic       parityAcc;
  logic       parErrFrame;
  logic       sampleTick;
  logic       bitEnd;
  logic       startEdge;
  logic       commit;
  logic       frameErrNow;

  rx_bit_timer #(
    .DIVIDER_WIDTH      (DIVIDER_WIDTH),
    .CLOCK_PER_BIT_WIDTH(CLOCK_PER_BIT_WIDTH)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .clkPerCycle (clkPerCycle),
    .clocksPerBit(clocksPerBit),
    .clear       (state == IDLE),
    .comClk      (comClk),
    .sampleTick  (sampleTick),
    .bitEnd      (bitEnd)
  );

  // Two-flop synchronizer plus edge-history flop, all resetting to idle level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxMeta <= ~START_BIT;
      rxS    <= ~START_BIT;
      rxPrev <= ~START_BIT;
    end else begin
      rxMeta <= serialIn;
      rxS    <= rxMeta;
      rxPrev <= rxS;
    end
  end

  // Decode of the edge, bit placement and the commit strobe
  always_comb begin
    startEdge   = (rxPrev == ~START_BIT) && (rxS == START_BIT);
    bitIndex    = msbFirst ? (3'd7 - bitCounter) : bitCounter;
    commit      = (state == STOP) && sampleTick;
    frameErrNow = (rxS != STOP_BIT1);
  end

  // Frame sequencer with registered run / errSigOe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      run         <= 1'b0;
      errSigOe    <= 1'b0;
      bitCounter  <= '0;
      shiftReg    <= '0;
      parityAcc   <= 1'b0;
      parErrFrame <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (startEdge) begin
            state       <= START;
            run         <= 1'b1;
            parErrFrame <= 1'b0;
          end
        end
        START: begin
          if (sampleTick && (rxS != START_BIT)) begin
            state <= IDLE;
            run   <= 1'b0;
          end else if (bitEnd) begin
            state      <= DATA;
            bitCounter <= '0;
            parityAcc  <= oddParity;
          end
        end
        DATA: begin
          if (sampleTick) begin
            shiftReg[bitIndex] <= rxS;
            parityAcc          <= parityAcc ^ rxS;
          end
          if (bitEnd) begin
            if (bitCounter == 3'd7) begin
              state <= PARITY;
            end else begin
              bitCounter <= bitCounter + 1'b1;
            end
          end
        end
        PARITY: begin
          if (sampleTick) begin
            parErrFrame <= (rxS != parityAcc);
          end
          if (bitEnd) begin
            state <= STOP;
          end
        end
        STOP: begin
          if (sampleTick) begin
            if (parErrFrame && errSigEnable) begin
              state    <= ERRSIG;
              errSigOe <= 1'b1;
            end else begin
              state <= IDLE;
              run   <= 1'b0;
            end
          end
        end
        ERRSIG: begin
          // Entered on a mid-bit tick; the next mid-bit tick is clocksPerBit ticks later
          if (sampleTick) begin
            state    <= IDLE;
            run      <= 1'b0;
            errSigOe <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          run      <= 1'b0;
          errSigOe <= 1'b0;
        end
      endcase
    end
  end

  // Holding buffer: commit takes priority over a coincident acknowledge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataOut     <= '0;
      bufferFull  <= 1'b0;
      parityError <= 1'b0;
      frameError  <= 1'b0;
      overrun     <= 1'b0;
    end else if (commit) begin
      if (!bufferFull || ackFlags) begin
        dataOut     <= shiftReg;
        bufferFull  <= 1'b1;
        parityError <= parErrFrame;
        frameError  <= frameErrNow;
        overrun     <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else if (ackFlags) begin
      bufferFull  <= 1'b0;
      parityError <= 1'b0;
      frameError  <= 1'b0;
      overrun     <= 1'b0;
    end
  end

endmodule

// File: doc/iso_rx_core.md
# iso_rx_core

ISO7816-3 / UART-style character receiver, the receive-side counterpart of the team's transmit core. It samples the asynchronous `serialIn` line on an elementary-time-unit (ETU) grid, rebuilds one 8-bit character, and checks parity and the stop bit. It drives the ISO7816 error signal when parity fails. The received byte and its status flags sit in a single-entry holding buffer until the host acknowledges them.

## Interface
- `DIVIDER_WIDTH`, 1: width of `clkPerCycle`.
- `CLOCK_PER_BIT_WIDTH`, 13: width of `clocksPerBit` and of the ETU counter. Supports the ISO7816 default of 372.
- `START_BIT`, 1'b0: start-bit level. The idle level is `~START_BIT`.
- `STOP_BIT1`, 1'b1: expected stop-bit level.
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `serialIn` in 1: asynchronous line input.
- `clkPerCycle` in DIVIDER_WIDTH: one comClk tick every `clkPerCycle+1` clk cycles.
- `clocksPerBit` in CLOCK_PER_BIT_WIDTH: comClk ticks per ETU. Must be ≥ 4 and must stay static while `run`=1.
- `oddParity` in 1: 1 means data+parity must hold an odd number of ones.
- `msbFirst` in 1: 1 means the first data bit received lands in b7.
- `errSigEnable` in 1: enables ISO7816 error signalling.
- `ackFlags` in 1: one-cycle pulse. Clears `bufferFull`, `overrun`, `parityError` and `frameError`.
- `comClk` out 1: divided clock-enable strobe.
- `dataOut` out 8: last accepted byte.
- `bufferFull` out 1: `dataOut` holds an unacknowledged byte.
- `parityError`, `frameError`, `overrun` out 1 each: sticky status flags.
- `run` out 1: a frame is in progress (state ≠ IDLE).
- `errSigOe` out 1: when 1, the pad drives the line to START_BIT level.

## Operation
- **Input synchronizer:** `serialIn` passes through a 2-flop synchronizer, reset to the idle level, giving `rxS`.
- **States:** IDLE, START, DATA, PARITY, STOP, ERRSIG.
- **ETU counter:**
  - Advances only on comClk ticks.
  - Cleared in IDLE.
  - Wraps at `clocksPerBit-1`, which defines the bit boundary.
- **Sample point:** the tick where the count equals `clocksPerBit>>1` (integer shift).
- **IDLE → START:** on an idle-to-START_BIT edge of `rxS`.
- **START:**
  - If the sample is not START_BIT, the event is a glitch: return to IDLE and set no flags.
  - Otherwise go to DATA at the bit boundary.
- **DATA:**
  - Eight samples stored at index `bitCounter`, or `7-bitCounter` when `msbFirst`=1.
  - Running parity starts at `oddParity` and is XORed with each sample.
  - Go to PARITY after bit 7.
- **PARITY:** parity error if the sample ≠ running parity. Go to STOP at the boundary.
- **STOP sample point:**
  - Frame error if the sample ≠ STOP_BIT1.
  - Commit the character to the buffer.
  - If parity error and `errSigEnable`=1: go to ERRSIG. Otherwise go to IDLE. A next start edge is then accepted from half a stop bit onward.
- **ERRSIG:**
  - `errSigOe`=1 for exactly `clocksPerBit` comClk ticks, i.e. 10.5 to 11.5 ETU from the start edge.
  - Then IDLE.
  - Start edges are ignored while in ERRSIG.
- **Commit rules:**
  - If `bufferFull`=0: load `dataOut`, set `bufferFull`, set `parityError`/`frameError` from this frame.
  - If `bufferFull`=1: discard the byte, set `overrun`, and leave `dataOut` and the other flags unchanged.
- **Commit and `ackFlags` in the same cycle:** the commit wins. `bufferFull`=1, flags take the new frame's values, `overrun`=0.
- **Reset:**
  - All outputs go to 0, the buffer to 0x00, state to IDLE, counters to 0.
  - Reset mid-frame abandons the frame with no flags set.

## Timing
- Start-edge detection lags `serialIn` by 2–3 clk.
- The ETU counter starts from 0 on the clk after entering START.
- Status and `dataOut` update on the clk edge after the STOP sample tick.
- `errSigOe` rises on that same edge. It falls on the edge after the last ERRSIG tick.
- `run` falls on the same edge that enters IDLE.
- `comClk` is a one-clk-wide pulse.
- With `clkPerCycle`=0, `comClk`=1 continuously.

## Structure
- **Package `iso7816_pkg`:** the state enum, the START_BIT/STOP_BIT1 defaults, and the minimum `clocksPerBit` constant (4).
- **Sub-module `rx_bit_timer`:** clk divider plus the ETU counter, with sample-point and bit-boundary strobes. The FSM and buffer stay in `iso_rx_core`.

## Test plan
Common settings for all scenarios: `clkPerCycle`=0, `clocksPerBit`=16.
1. Send 0x3B LSB-first, even parity (`oddParity`=0), parity bit 1, one stop bit → `dataOut`=0x3B, `bufferFull`=1, no error flags; `ackFlags` then clears `bufferFull`.
2. `msbFirst`=1, `oddParity`=1, line bits 0,0,1,1,1,0,1,1 (b7 first), parity 0 → `dataOut`=0x3B, no errors.
3. Send 0x3B with parity bit 0 and `errSigEnable`=1 → `parityError`=1, `errSigOe`=1 for exactly 16 clk starting 8 clk after the STOP bit begins.
4. Hold START_BIT for 4 clk only → state returns to IDLE, `run` falls, all flags stay 0.
5. Send two frames without `ackFlags` → `dataOut` holds the first byte, `overrun`=1. Then assert `ackFlags` in the commit cycle of a third frame → `bufferFull`=1, `overrun`=0.
6. Stop bit sampled at 0 → `frameError`=1. Then assert `reset` mid-DATA of the next frame → all outputs 0, and a following clean frame is received correctly.
